axi4_wb_drop_responder: RTL and testbench
=========================================

# axi4_wb_drop_responder

Write-path counterpart of the RAB read-response injector. For every write the RAB decides to drop (translation miss, protection or multi-hit), the block sinks that write's W beats from the slave port so they never reach the master port. It then injects a B response with the original ID into the slave-port B channel, merged with B responses forwarded from the master port. It sits between the RAB slave port and the master port on the W and B channels.

## Interface
Parameters:
- AXI_DATA_WIDTH, 32, W data width
- AXI_ID_WIDTH, 4, ID width
- AXI_USER_WIDTH, 4, user width
- BUFFER_DEPTH, 16, depth of decision FIFO and inject FIFO

Ports:
- axi4_aclk  in  1  clock
- axi4_arstn  in  1  reset, asynchronous, active-low
- aw_valid_i  in  1  one AW decision offered (one per AW accepted by the RAB, in AW order)
- aw_drop_i  in  1  1 = drop this write, 0 = forward
- aw_id_i  in  AXI_ID_WIDTH  AWID of the decided write
- prefetch_i, hit_i  in  1 each  attributes of a dropped write
- aw_ready_o  out  1  decision FIFO not full
- done_o  out  1  decision accepted this cycle (aw_valid_i & aw_ready_o)
- s_axi4_wdata/wstrb/wlast/wuser/wvalid  in  slave W channel; s_axi4_wready out
- m_axi4_wdata/wstrb/wlast/wuser/wvalid  out  master W channel; m_axi4_wready in
- s_axi4_bid/bresp/buser/bvalid  out  slave B channel; s_axi4_bready in
- m_axi4_bid/bresp/buser/bvalid  in  master B channel; m_axi4_bready out

## Operation
- Decision FIFO entries: {drop, prefetch, hit, id}. Push on done_o.
- W FSM, states W_IDLE, W_FWD, W_DROP:
  - W_IDLE: s_axi4_wready=0, m_axi4_wvalid=0. If the decision FIFO head is valid, go to W_DROP when head.drop=1, otherwise W_FWD.
  - W_FWD: W payload passed through; m_axi4_wvalid=s_axi4_wvalid; s_axi4_wready=m_axi4_wready. On a handshake with wlast=1: pop the decision and go to W_IDLE.
  - W_DROP: m_axi4_wvalid=0; s_axi4_wready=inject FIFO ready. Each handshake discards the beat. On the wlast=1 handshake: pop the decision, push {id, resp} into the inject FIFO, and go to W_IDLE.
- Inject response: bresp=2'b00 if prefetch&hit, else 2'b10. buser=0.
- B merge arbiter:
  - Sources: the master B channel and the inject FIFO head.
  - With no grant locked, prefer the source not granted last (round-robin bit; reset value prefers inject).
  - Once s_axi4_bvalid is asserted, the grant is locked until the s_axi4_bready handshake. bid, bresp and buser stay stable while locked.
  - m_axi4_bready = s_axi4_bready & grant==fwd. Inject FIFO pops on a handshake with grant==inject.
- Same-ID ordering between forwarded and injected B is decided upstream: the RAB does not forward a write while a dropped write with the same ID is outstanding. This block does not reorder.

## Timing
- Reset values:
  - FSM = W_IDLE.
  - All valids and readies = 0, except aw_ready_o, which is 1 (FIFO empty).
  - done_o=0; round-robin bit = prefer inject.
- Decision pushed in cycle t is visible at the FIFO head in t+1. The FSM leaves W_IDLE at t+2; the first W beat can be accepted in t+2.
- Back-to-back writes: one W_IDLE cycle between consecutive bursts.
- Injected B: pushed on the last-beat cycle c. s_axi4_bvalid is asserted in c+1 at the earliest.
- Decision FIFO full: aw_ready_o=0, done_o=0.
- Inject FIFO full in W_DROP: s_axi4_wready=0 for all beats until there is space.
- Single-beat burst (wlast on the first beat) is handled identically.
- Simultaneous inject push and pop: both happen; occupancy is unchanged.
- Reset mid-burst: all state is cleared and the FIFOs are emptied. No partial B is emitted.

## Structure
- A shared package rab_axi_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the W FSM enum;
  - the decision entry struct.
- Sub-module axi_buffer_rab is instantiated twice: the decision FIFO and the inject FIFO.
- The B arbiter is inline.

## Test plan
- Forward one 4-beat write with id 3 (drop=0): 4 beats appear on the master W channel unchanged. The master B {id 3, OKAY} reaches the slave port; no injection.
- Drop a 4-beat write with id 5 (prefetch=0, hit=0): s_axi4_wready is high for 4 beats and m_axi4_wvalid stays 0. The slave port gets exactly one B {id 5, 2'b10}, one cycle after the last beat at the earliest.
- Drop a 1-beat write with prefetch=1, hit=1: the injected B has bresp 2'b00 and buser 0.
- Forwarded B and injected B pending simultaneously, with s_axi4_bready held low for 3 cycles: the first-granted B stays stable for all 3 cycles. After the handshake, the other source is granted next.
- Push 16 drop decisions without W data: aw_ready_o goes low on the 17th. Supplying all the bursts with bready low fills the inject FIFO, and s_axi4_wready drops until B handshakes free space.
- Assert reset during beat 2 of a dropped 4-beat write: after reset all outputs are at their reset values and no B is emitted. A following write is handled normally.

Source files
------------

// File: rtl/rab_axi_pkg.sv
// Shared types for the RAB write-drop path: response codes, W FSM states and
// the per-write decision attributes (the AWID travels next to this struct).
package rab_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FWD,
        W_DROP
    } w_state_e;

    typedef struct packed {
        logic drop;
        logic prefetch;
        logic hit;
    } rab_dec_t;

    // A dropped prefetch that still hit is answered benignly; all else errors.
    function automatic logic [1:0] drop_resp(input rab_dec_t dec);
        return (dec.prefetch && dec.hit) ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_buffer_rab.sv
// Valid/ready FIFO used for both the AW decision queue and the B inject queue.
module axi_buffer_rab #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BUFFER_DEPTH = 16
) (
    input  logic                  axi4_aclk,
    input  logic                  axi4_arstn,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int unsigned PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  push, pop;

    assign ready_o = (cnt_q != CNT_FULL);
    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge axi4_aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/axi4_wb_drop_responder.sv
// Sinks W beats of RAB-dropped writes and injects their B responses into the
// slave B channel, merged round-robin with B traffic from the master port.
//
// state  | meaning
// W_IDLE | waiting for a decision at the FIFO head; W stalled
// W_FWD  | passing the current burst through to the master port
// W_DROP | swallowing the current burst; B is queued on its last beat
module axi4_wb_drop_responder
    import rab_axi_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 4,
    parameter int unsigned BUFFER_DEPTH   = 16
) (
    input  logic                        axi4_aclk,
    input  logic                        axi4_arstn,

    input  logic                        aw_valid_i,
    input  logic                        aw_drop_i,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
    input  logic                        prefetch_i,
    input  logic                        hit_i,
    output logic                        aw_ready_o,
    output logic                        done_o,

    input  logic [AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
    input  logic                        s_axi4_wlast,
    input  logic [AXI_USER_WIDTH-1:0]   s_axi4_wuser,
    input  logic                        s_axi4_wvalid,
    output logic                        s_axi4_wready,

    output logic [AXI_DATA_WIDTH-1:0]   m_axi4_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb,
    output logic                        m_axi4_wlast,
    output logic [AXI_USER_WIDTH-1:0]   m_axi4_wuser,
    output logic                        m_axi4_wvalid,
    input  logic                        m_axi4_wready,

    output logic [AXI_ID_WIDTH-1:0]     s_axi4_bid,
    output logic [1:0]                  s_axi4_bresp,
    output logic [AXI_USER_WIDTH-1:0]   s_axi4_buser,
    output logic                        s_axi4_bvalid,
    input  logic                        s_axi4_bready,

    input  logic [AXI_ID_WIDTH-1:0]     m_axi4_bid,
    input  logic [1:0]                  m_axi4_bresp,
    input  logic [AXI_USER_WIDTH-1:0]   m_axi4_buser,
    input  logic                        m_axi4_bvalid,
    output logic                        m_axi4_bready
);

    localparam int unsigned DEC_W = $bits(rab_dec_t) + AXI_ID_WIDTH;
    localparam int unsigned INJ_W = AXI_ID_WIDTH + 2;

    rab_dec_t                dec_in, dec_head;
    logic [AXI_ID_WIDTH-1:0] dec_head_id;
    logic [DEC_W-1:0]        dec_wdata, dec_rdata;
    logic                    dec_valid, dec_pop;

    logic [INJ_W-1:0]        inj_wdata, inj_rdata;
    logic                    inj_push, inj_ready, inj_valid, inj_pop;
    logic [AXI_ID_WIDTH-1:0] inj_id;
    logic [1:0]              inj_resp;

    w_state_e                state_q;
    logic                    w_hs, w_last_hs;

    logic                    gnt_inj;
    logic                    lock_q, lock_d;
    logic                    lock_gnt_q, lock_gnt_d;
    logic                    rr_inj_q, rr_inj_d;

    assign dec_in    = '{drop: aw_drop_i, prefetch: prefetch_i, hit: hit_i};
    assign dec_wdata = {dec_in, aw_id_i};
    assign {dec_head, dec_head_id} = dec_rdata;
    assign done_o    = aw_valid_i & aw_ready_o;

    axi_buffer_rab #(
        .DATA_WIDTH   (DEC_W),
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_dec_fifo (
        .axi4_aclk  (axi4_aclk),
        .axi4_arstn (axi4_arstn),
        .data_i     (dec_wdata),
        .valid_i    (aw_valid_i),
        .ready_o    (aw_ready_o),
        .data_o     (dec_rdata),
        .valid_o    (dec_valid),
        .ready_i    (dec_pop)
    );

    // W payload is always wired through; only the handshake is steered.
    assign m_axi4_wdata = s_axi4_wdata;
    assign m_axi4_wstrb = s_axi4_wstrb;
    assign m_axi4_wlast = s_axi4_wlast;
    assign m_axi4_wuser = s_axi4_wuser;

    always_comb begin
        s_axi4_wready = 1'b0;
        m_axi4_wvalid = 1'b0;
        case (state_q)
            W_FWD: begin
                m_axi4_wvalid = s_axi4_wvalid;
                s_axi4_wready = m_axi4_wready;
            end
            W_DROP:  s_axi4_wready = inj_ready;
            default: ;
        endcase
    end

    assign w_hs      = s_axi4_wvalid & s_axi4_wready;
    assign w_last_hs = w_hs & s_axi4_wlast;
    assign dec_pop   = w_last_hs;
    assign inj_push  = w_last_hs & (state_q == W_DROP);
    assign inj_wdata = {dec_head_id, drop_resp(dec_head)};

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            state_q <= W_IDLE;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (dec_valid) begin
                        state_q <= dec_head.drop ? W_DROP : W_FWD;
                    end
                end
                W_FWD, W_DROP: begin
                    if (w_last_hs) begin
                        state_q <= W_IDLE;
                    end
                end
                default: state_q <= W_IDLE;
            endcase
        end
    end

    axi_buffer_rab #(
        .DATA_WIDTH   (INJ_W),
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_inj_fifo (
        .axi4_aclk  (axi4_aclk),
        .axi4_arstn (axi4_arstn),
        .data_i     (inj_wdata),
        .valid_i    (inj_push),
        .ready_o    (inj_ready),
        .data_o     (inj_rdata),
        .valid_o    (inj_valid),
        .ready_i    (inj_pop)
    );

    assign {inj_id, inj_resp} = inj_rdata;

    // A presented B keeps its source until it is taken, so the payload is stable.
    always_comb begin
        if (lock_q) begin
            gnt_inj = lock_gnt_q;
        end else if (inj_valid && m_axi4_bvalid) begin
            gnt_inj = rr_inj_q;
        end else begin
            gnt_inj = inj_valid;
        end
        s_axi4_bvalid = gnt_inj ? inj_valid : m_axi4_bvalid;
        s_axi4_bid    = gnt_inj ? inj_id    : m_axi4_bid;
        s_axi4_bresp  = gnt_inj ? inj_resp  : m_axi4_bresp;
        s_axi4_buser  = gnt_inj ? '0        : m_axi4_buser;
        m_axi4_bready = s_axi4_bready & ~gnt_inj;
        inj_pop       = s_axi4_bready & gnt_inj;
        lock_d        = s_axi4_bvalid & ~s_axi4_bready;
        lock_gnt_d    = gnt_inj;
        rr_inj_d      = (s_axi4_bvalid && s_axi4_bready) ? ~gnt_inj : rr_inj_q;
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            lock_q     <= 1'b0;
            lock_gnt_q <= 1'b0;
            rr_inj_q   <= 1'b1;
        end else begin
            lock_q     <= lock_d;
            lock_gnt_q <= lock_gnt_d;
            rr_inj_q   <= rr_inj_d;
        end
    end

endmodule

// File: tb/tb_axi4_wb_drop_responder.sv
// Directed bench for the write-drop responder: forward, drop, B merge,
// FIFO-full back-pressure and mid-burst reset.
module tb_axi4_wb_drop_responder;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        aw_valid = 1'b0, aw_drop = 1'b0, prefetch = 1'b0, hit = 1'b0;
    logic [3:0]  aw_id = '0;
    logic        aw_ready, done;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0, s_wuser = '0;
    logic        s_wlast = 1'b0, s_wvalid = 1'b0, s_wready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb, m_wuser;
    logic        m_wlast, m_wvalid, m_wready = 1'b0;
    logic [3:0]  s_bid, s_buser;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready = 1'b0;
    logic [3:0]  m_bid = '0, m_buser = '0;
    logic [1:0]  m_bresp = '0;
    logic        m_bvalid = 1'b0, m_bready;

    int n_cmp = 0;
    int n_err = 0;
    int b_hs  = 0;
    int fw, hs0;

    always #5 clk = ~clk;

    axi4_wb_drop_responder dut (
        .axi4_aclk(clk), .axi4_arstn(arstn),
        .aw_valid_i(aw_valid), .aw_drop_i(aw_drop), .aw_id_i(aw_id),
        .prefetch_i(prefetch), .hit_i(hit), .aw_ready_o(aw_ready), .done_o(done),
        .s_axi4_wdata(s_wdata), .s_axi4_wstrb(s_wstrb), .s_axi4_wlast(s_wlast),
        .s_axi4_wuser(s_wuser), .s_axi4_wvalid(s_wvalid), .s_axi4_wready(s_wready),
        .m_axi4_wdata(m_wdata), .m_axi4_wstrb(m_wstrb), .m_axi4_wlast(m_wlast),
        .m_axi4_wuser(m_wuser), .m_axi4_wvalid(m_wvalid), .m_axi4_wready(m_wready),
        .s_axi4_bid(s_bid), .s_axi4_bresp(s_bresp), .s_axi4_buser(s_buser),
        .s_axi4_bvalid(s_bvalid), .s_axi4_bready(s_bready),
        .m_axi4_bid(m_bid), .m_axi4_bresp(m_bresp), .m_axi4_buser(m_buser),
        .m_axi4_bvalid(m_bvalid), .m_axi4_bready(m_bready)
    );

    always @(posedge clk) begin
        if (arstn && s_bvalid && s_bready) b_hs <= b_hs + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge (decision pushed).
    task automatic push_dec(input logic drop, input logic pf, input logic ht, input logic [3:0] id);
        aw_valid = 1'b1; aw_drop = drop; prefetch = pf; hit = ht; aw_id = id;
        #1 check_val("done", done, 1);
        @(negedge clk);
        aw_valid = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the last beat handshake.
    task automatic send_burst(input int n, input logic fwd, input logic [3:0] tag,
                              input logic chk_b, output int first_wait);
        int waits;
        logic got;
        logic [31:0] d;
        first_wait = -1;
        for (int i = 0; i < n; i++) begin
            d = 32'hA000_0000 | (32'(tag) << 8) | 32'(i);
            s_wdata = d; s_wstrb = 4'(4'hF - i); s_wuser = 4'(i);
            s_wlast = (i == n - 1); s_wvalid = 1'b1;
            waits = 0; got = 1'b0;
            while (!got && waits < 40) begin
                #1;
                if (s_wready) got = 1'b1;
                else begin @(negedge clk); waits++; end
            end
            if (!got) check_val("wready_timeout", 0, 1);
            else if (fwd) begin
                check_val("m_wvalid", m_wvalid, 1);
                check_val("m_wdata", m_wdata, d);
                check_val("m_wstrb", m_wstrb, 4'(4'hF - i));
                check_val("m_wlast", m_wlast, (i == n - 1));
            end else begin
                check_val("m_wvalid_drop", m_wvalid, 0);
                if (chk_b && i == n - 1) check_val("b_early", s_bvalid, 0);
            end
            if (i == 0) first_wait = waits;
            @(negedge clk);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_aw_ready", aw_ready, 1);
        check_val("rst_done", done, 0);
        check_val("rst_wready", s_wready, 0);
        check_val("rst_m_wvalid", m_wvalid, 0);
        check_val("rst_bvalid", s_bvalid, 0);
        check_val("rst_m_bready", m_bready, 0);
        arstn = 1'b1;
        m_wready = 1'b1;
        @(negedge clk);

        // forward 4-beat id 3
        push_dec(0, 0, 0, 4'd3);
        send_burst(4, 1, 4'd3, 0, fw);
        check_val("fwd_latency", fw, 1);
        m_bvalid = 1'b1; m_bid = 4'd3; m_bresp = 2'b00; m_buser = 4'h5; s_bready = 1'b1;
        #1;
        check_val("fwd_bvalid", s_bvalid, 1);
        check_val("fwd_bid", s_bid, 3);
        check_val("fwd_bresp", s_bresp, 0);
        check_val("fwd_buser", s_buser, 5);
        check_val("fwd_m_bready", m_bready, 1);
        @(negedge clk);
        m_bvalid = 1'b0;
        #1 check_val("fwd_no_inject", s_bvalid, 0);
        @(negedge clk);

        // drop 4-beat id 5, slverr
        hs0 = b_hs;
        push_dec(1, 0, 0, 4'd5);
        send_burst(4, 0, 4'd5, 1, fw);
        check_val("drop_latency", fw, 1);
        #1;
        check_val("drop_bvalid", s_bvalid, 1);
        check_val("drop_bid", s_bid, 5);
        check_val("drop_bresp", s_bresp, 2'b10);
        check_val("drop_buser", s_buser, 0);
        @(negedge clk);
        #1 check_val("drop_b_gone", s_bvalid, 0);
        check_val("drop_b_once", b_hs - hs0, 1);
        @(negedge clk);

        // drop single beat, prefetch hit -> okay
        push_dec(1, 1, 1, 4'd9);
        send_burst(1, 0, 4'd9, 1, fw);
        #1;
        check_val("pf_bvalid", s_bvalid, 1);
        check_val("pf_bid", s_bid, 9);
        check_val("pf_bresp", s_bresp, 2'b00);
        check_val("pf_buser", s_buser, 0);
        @(negedge clk);

        // both pending, bready low 3 cycles; last grant was inject so fwd wins
        s_bready = 1'b0;
        push_dec(1, 0, 0, 4'd6);
        send_burst(1, 0, 4'd6, 0, fw);
        m_bvalid = 1'b1; m_bid = 4'd2; m_bresp = 2'b01; m_buser = 4'h3;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("arb_hold_bvalid", s_bvalid, 1);
            check_val("arb_hold_bid", s_bid, 2);
            check_val("arb_hold_bresp", s_bresp, 2'b01);
            check_val("arb_hold_m_bready", m_bready, 0);
            @(negedge clk);
        end
        s_bready = 1'b1;
        #1 check_val("arb_m_bready", m_bready, 1);
        @(negedge clk);
        m_bid = 4'd4; m_bresp = 2'b00; m_buser = 4'h1;
        #1;
        check_val("arb_next_bid", s_bid, 6);
        check_val("arb_next_bresp", s_bresp, 2'b10);
        check_val("arb_next_m_bready", m_bready, 0);
        @(negedge clk);
        #1 check_val("arb_then_fwd", s_bid, 4);
        @(negedge clk);
        m_bvalid = 1'b0;
        #1 check_val("arb_empty", s_bvalid, 0);

        // fill decision FIFO then inject FIFO
        s_bready = 1'b0;
        for (int i = 0; i < 16; i++) push_dec(1, 0, 0, 4'(i));
        aw_valid = 1'b1; aw_drop = 1'b1; aw_id = 4'hA;
        #1;
        check_val("full_aw_ready", aw_ready, 0);
        check_val("full_done", done, 0);
        aw_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) send_burst(1, 0, 4'(i), 0, fw);
        push_dec(1, 0, 0, 4'hA);
        s_wdata = 32'hDEAD_0000; s_wstrb = 4'hF; s_wlast = 1'b1; s_wvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 check_val("inj_full_wready", s_wready, 0);
            @(negedge clk);
        end
        s_bready = 1'b1;
        #1 check_val("inj_full_bid0", s_bid, 0);
        @(negedge clk);
        s_bready = 1'b0;
        #1 check_val("inj_space_wready", s_wready, 1);
        @(negedge clk);
        s_wvalid = 1'b0; s_wlast = 1'b0;
        s_bready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            #1;
            check_val("drain_bvalid", s_bvalid, 1);
            check_val("drain_bid", s_bid, (k == 16) ? 4'hA : 4'(k));
            @(negedge clk);
        end
        #1 check_val("drain_empty", s_bvalid, 0);
        @(negedge clk);

        // reset during beat 2 of a dropped 4-beat write
        push_dec(1, 0, 0, 4'd7);
        s_wdata = 32'h1; s_wstrb = 4'hF; s_wlast = 1'b0; s_wvalid = 1'b1;
        @(negedge clk);
        #1 check_val("mid_beat1_wready", s_wready, 1);
        @(negedge clk);
        s_wdata = 32'h2;
        #1 check_val("mid_beat2_wready", s_wready, 1);
        hs0 = b_hs;
        arstn = 1'b0;
        #1;
        check_val("mid_rst_aw_ready", aw_ready, 1);
        check_val("mid_rst_wready", s_wready, 0);
        check_val("mid_rst_m_wvalid", m_wvalid, 0);
        check_val("mid_rst_bvalid", s_bvalid, 0);
        check_val("mid_rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        s_wvalid = 1'b0;
        arstn = 1'b1;
        repeat (5) @(negedge clk);
        #1 check_val("mid_no_b", s_bvalid, 0);
        check_val("mid_no_b_hs", b_hs - hs0, 0);
        @(negedge clk);
        push_dec(0, 0, 0, 4'd1);
        send_burst(2, 1, 4'd1, 0, fw);
        check_val("post_rst_latency", fw, 1);
        m_bvalid = 1'b1; m_bid = 4'd1; m_bresp = 2'b00; m_buser = 4'h2;
        #1;
        check_val("post_rst_bvalid", s_bvalid, 1);
        check_val("post_rst_bid", s_bid, 1);
        @(negedge clk);
        m_bvalid = 1'b0;
        #1 check_val("post_rst_b_done", s_bvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
